pattern_count_engine: RTL

//  Hardware accelerator for the program-3 bit-pattern search. Reads a PAT_W-bit pattern and a
//  LEN-byte message from data memory and counts three things: matches confined to one byte,

---
 rtl/pattern_count_engine.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pattern_count_engine.sv
// Bit-pattern search accelerator: reads a pattern and a message from data memory, counts
// within-byte matches, bytes containing a match, and bitstream-wide matches, then writes them back.
module pattern_count_engine #(
    parameter int unsigned PAT_W     = 5,
    parameter int unsigned BYTE_W    = 8,
    parameter int unsigned NUM_BYTES = 32,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned PAT_ADDR  = 32,
    parameter int unsigned RES_ADDR  = 33
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [BYTE_W-1:0] mem_wr_data,
    input  logic [BYTE_W-1:0] mem_rd_data,
    output logic [CNT_W-1:0]  cnt_within,
    output logic [CNT_W-1:0]  cnt_bytes,
    output logic [CNT_W-1:0]  cnt_cross
);

    localparam int unsigned LEN_W  = $clog2(NUM_BYTES + 1);
    localparam int unsigned IDX_W  = $clog2(NUM_BYTES + 2);
    localparam int unsigned MW     = $clog2(BYTE_W + 1);
    localparam int unsigned SUM_W  = ((CNT_W > MW) ? CNT_W : MW) + 1;
    localparam int unsigned TAIL_W = (PAT_W > 1) ? PAT_W - 1 : 1;
    localparam int unsigned C_W    = BYTE_W + TAIL_W;
    localparam int unsigned WIN_N  = BYTE_W - PAT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_PAT = 3'd1,
        SCAN   = 3'd2,
        WB0    = 3'd3,
        WB1    = 3'd4,
        WB2    = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_clamped;
    logic [IDX_W-1:0]  idx_q;
    logic [PAT_W-1:0]  pat_q;
    logic [TAIL_W-1:0] tail_q;
    logic              accept;
    logic              scan_last;

    logic              busy_d, done_d, wr_en_d;
    logic [ADDR_W-1:0] addr_d;
    logic [BYTE_W-1:0] wr_data_d;

    logic [MW-1:0]     within_n, cross_all_n, cross_n;
    logic [C_W-1:0]    c_word;

    assign accept      = start && ((state_q == IDLE) || (state_q == DONE));
    assign scan_last   = (idx_q == IDX_W'(len_q) + IDX_W'(1));
    assign len_clamped = (32'(len) > NUM_BYTES) ? LEN_W'(NUM_BYTES) : LEN_W'(len);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [MW-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(s);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RD_PAT;
            RD_PAT:     state_d = SCAN;
            SCAN:       if (scan_last) state_d = WB0;
            WB0:        state_d = WB1;
            WB1:        state_d = WB2;
            WB2:        state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Output logic: next values for the registered memory/status outputs
    always_comb begin
        busy_d    = busy;
        done_d    = done;
        addr_d    = '0;
        wr_en_d   = 1'b0;
        wr_data_d = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    done_d = 1'b0;
                end
            end
            DONE: begin
                if (start) begin
                    busy_d = 1'b1;
                    done_d = 1'b0;
                end else begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            RD_PAT: addr_d = ADDR_W'(PAT_ADDR);
            SCAN: begin
                if (idx_q < IDX_W'(len_q)) addr_d = base_q + ADDR_W'(idx_q);
            end
            WB0: begin
                addr_d    = ADDR_W'(RES_ADDR);
                wr_en_d   = 1'b1;
                wr_data_d = BYTE_W'(cnt_within);
            end
            WB1: begin
                addr_d    = ADDR_W'(RES_ADDR + 1);
                wr_en_d   = 1'b1;
                wr_data_d = BYTE_W'(cnt_bytes);
            end
            WB2: begin
                addr_d    = ADDR_W'(RES_ADDR + 2);
                wr_en_d   = 1'b1;
                wr_data_d = BYTE_W'(cnt_cross);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            mem_addr    <= addr_d;
            mem_wr_en   <= wr_en_d;
            mem_wr_data <= wr_data_d;
        end
    end

    // Window matches for the byte on mem_rd_data; tail bits extend windows back into the previous byte
    always_comb begin
        within_n    = '0;
        cross_all_n = '0;
        c_word      = {tail_q, mem_rd_data};
        for (int k = 0; k < int'(WIN_N); k++) begin
            if (mem_rd_data[k +: PAT_W] == pat_q) within_n = within_n + MW'(1);
        end
        for (int k = 0; k < int'(BYTE_W); k++) begin
            if (c_word[k +: PAT_W] == pat_q) cross_all_n = cross_all_n + MW'(1);
        end
        cross_n = (idx_q == IDX_W'(2)) ? within_n : cross_all_n;
    end

    // Run context and counters; SCAN index 1 carries the pattern, index 2+i carries byte i
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            pat_q      <= '0;
            tail_q     <= '0;
            cnt_within <= '0;
            cnt_bytes  <= '0;
            cnt_cross  <= '0;
        end else if (accept) begin
            base_q     <= base_addr;
            len_q      <= len_clamped;
            idx_q      <= '0;
            tail_q     <= '0;
            cnt_within <= '0;
            cnt_bytes  <= '0;
            cnt_cross  <= '0;
        end else if (state_q == SCAN) begin
            idx_q <= idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(1)) pat_q <= mem_rd_data[BYTE_W-1 -: PAT_W];
            if (idx_q >= IDX_W'(2)) begin
                cnt_within <= sat_add(cnt_within, within_n);
                cnt_bytes  <= sat_add(cnt_bytes, (within_n != '0) ? MW'(1) : MW'(0));
                cnt_cross  <= sat_add(cnt_cross, cross_n);
                tail_q     <= mem_rd_data[TAIL_W-1:0];
            end
        end
    end

endmodule
